bw_clk_cl_hdr_seq: RTL and testbench

Parametrised multi-channel cluster clock header controller. It synchronises global reset and debug-init into the `gclk` domain, and synchronises a per-channel clock-enable request for each of `NUM_CH` cluster grid-driver groups. Channel enable changes are sequenced so that at most one grid group switches per `STAGGER` cycles, which bounds di/dt on the clock grid. It sits between the global clock/reset distribution and the external per-channel clock gating cells and grid drivers.

---
 rtl/bw_clk_cl_hdr_seq.sv | 156 +++++++++++++++
 tb/tb_bw_clk_cl_hdr_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bw_clk_cl_hdr_seq.sv
// Cluster clock header: reset/debug-init/clock-enable synchronisers plus a staggered
// per-channel enable sequencer. Optional macro BW_CLK_DBGINIT_SYNC_EN builds the debug-init synchroniser.
module bw_clk_cl_hdr_seq #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER     = 4
) (
    input  logic              gclk,
    input  logic              arst,
    input  logic              grst_l,
    input  logic              gdbginit_l,
    input  logic [NUM_CH-1:0] cluster_cken,
    input  logic              se,
    input  logic              si,
    output logic              so,
    output logic [NUM_CH-1:0] rclk_en,
    output logic [NUM_CH-1:0] cluster_grst_l,
    output logic              dbginit_l,
    output logic              seq_busy
);

    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0]             rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] req_sync_q, req_sync_d;
    logic                               rst_s;
    logic [NUM_CH-1:0]                  req_s, pend_s, low_s;
    logic [NUM_CH-1:0]                  ch_on_q, ch_on_d;
    logic [NUM_CH-1:0]                  grst_q, grst_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    state_t                             state_q, state_d;

    // Synchroniser shift chains for grst_l and the per-channel enable requests
    always_comb begin
        rst_sync_d    = {rst_sync_q[SYNC_STAGES-2:0], grst_l};
        req_sync_d    = req_sync_q;
        req_sync_d[0] = cluster_cken;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            req_sync_d[s] = req_sync_q[s-1];
        end
    end

    // Synchroniser flops
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            rst_sync_q <= '0;
            req_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            req_sync_q <= req_sync_d;
        end
    end

    assign rst_s  = rst_sync_q[SYNC_STAGES-1];
    assign req_s  = req_sync_q[SYNC_STAGES-1];
    assign pend_s = req_s ^ ch_on_q;
    // Isolate the lowest-index pending channel
    assign low_s  = pend_s & (~pend_s + NUM_CH'(1));

`ifdef BW_CLK_DBGINIT_SYNC_EN
    logic [SYNC_STAGES-1:0] dbg_sync_q, dbg_sync_d;

    // Debug-init synchroniser chain
    always_comb begin
        dbg_sync_d = {dbg_sync_q[SYNC_STAGES-2:0], gdbginit_l};
    end

    // Debug-init synchroniser flops
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            dbg_sync_q <= '0;
        end else begin
            dbg_sync_q <= dbg_sync_d;
        end
    end

    assign dbginit_l = dbg_sync_q[SYNC_STAGES-1];
`else
    logic dbg_unused_s;
    assign dbg_unused_s = gdbginit_l;
    assign dbginit_l    = 1'b1;
`endif

    // Sequencer next state; scan mode shifts ch_on and freezes the FSM and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_on_d = ch_on_q;
        if (se) begin
            ch_on_d[0] = si;
            for (int i = 1; i < NUM_CH; i++) begin
                ch_on_d[i] = ch_on_q[i-1];
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pend_s) begin
                        ch_on_d = ch_on_q ^ low_s;
                        if (STAGGER > 1) begin
                            cnt_d   = CNT_W'(STAGGER - 1);
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A channel stays in reset while its grid is gated off
    always_comb begin
        grst_d = {NUM_CH{rst_s}} & ch_on_q;
    end

    // Sequencer and cluster reset registers
    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_on_q <= '0;
            grst_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_on_q <= ch_on_d;
            grst_q  <= grst_d;
        end
    end

    // Scan forces every grid on, except while arst holds the block in reset
    assign rclk_en        = ch_on_q | {NUM_CH{se & ~arst}};
    assign so             = ch_on_q[NUM_CH-1];
    assign cluster_grst_l = grst_q;
    assign seq_busy       = (state_q == ST_WAIT) | (|pend_s);

endmodule

// File: tb/tb_bw_clk_cl_hdr_seq.sv
// Directed table-driven bench for bw_clk_cl_hdr_seq (default build, STAGGER 4 and STAGGER 1).
module tb_bw_clk_cl_hdr_seq;

    typedef struct {
        logic       arst;
        logic       se;
        logic       si;
        logic [3:0] cken;
        logic [3:0] rclk;
        logic [3:0] grst;
        logic       so;
        logic       busy;
    } vec_t;

    logic       gclk = 1'b0;
    logic       arst, grst_l, gdbginit_l, se, si;
    logic [3:0] cken;
    logic       so, dbginit_l, busy;
    logic [3:0] rclk_en, cl_grst_l;

    logic       se1 = 1'b0;
    logic       si1 = 1'b0;
    logic [3:0] cken1;
    logic       so1, dbg1, busy1;
    logic [3:0] rclk1, grst1;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t tbl2[$];

    always #5 gclk = ~gclk;

    bw_clk_cl_hdr_seq #(.NUM_CH(4), .SYNC_STAGES(2), .STAGGER(4)) u_dut (
        .gclk(gclk), .arst(arst), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
        .cluster_cken(cken), .se(se), .si(si), .so(so), .rclk_en(rclk_en),
        .cluster_grst_l(cl_grst_l), .dbginit_l(dbginit_l), .seq_busy(busy)
    );

    bw_clk_cl_hdr_seq #(.NUM_CH(4), .SYNC_STAGES(2), .STAGGER(1)) u_s1 (
        .gclk(gclk), .arst(arst), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
        .cluster_cken(cken1), .se(se1), .si(si1), .so(so1), .rclk_en(rclk1),
        .cluster_grst_l(grst1), .dbginit_l(dbg1), .seq_busy(busy1)
    );

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic s, input logic i, input logic [3:0] c,
                                input logic [3:0] r, input logic [3:0] g, input logic o,
                                input logic b);
        vec_t v;
        v.arst = a; v.se = s; v.si = i; v.cken = c;
        v.rclk = r; v.grst = g; v.so = o; v.busy = b;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int row);
        arst = v.arst; se = v.se; si = v.si; cken = v.cken;
        tick();
        chk("rclk_en", row, {12'd0, rclk_en}, {12'd0, v.rclk});
        chk("cluster_grst_l", row, {12'd0, cl_grst_l}, {12'd0, v.grst});
        chk("so", row, {15'd0, so}, {15'd0, v.so});
        chk("seq_busy", row, {15'd0, busy}, {15'd0, v.busy});
        chk("dbginit_l", row, {15'd0, dbginit_l}, 16'd1);
    endtask

    initial begin
        arst = 1'b1; grst_l = 1'b1; gdbginit_l = 1'b1; cken = 4'hf; se = 1'b1; si = 1'b1;
        cken1 = 4'h0;

        // reset with all inputs high, then release with channel 0 requested
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0));
        // stagger up to 1111
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011, 4'b0001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011, 4'b0011, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011, 4'b0011, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011, 4'b0011, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0111, 4'b0011, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0111, 4'b0111, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0111, 4'b0111, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0111, 4'b0111, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0111, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0));
        // stagger down, channel 3 restored before it is serviced
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1111, 4'b1111, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1110, 4'b1111, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1110, 4'b1110, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1110, 4'b1110, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1110, 4'b1110, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1100, 4'b1110, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1100, 4'b1100, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1100, 4'b1100, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1100, 4'b1100, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1100, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0));
        // enter WAIT, then scan 1,0,1,1 with the counter frozen
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 4'b1000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1001, 4'b1111, 4'b1001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b1001, 4'b1111, 4'b0011, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1001, 4'b1111, 4'b0110, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1001, 4'b1111, 4'b1101, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1011, 4'b1011, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1011, 4'b1011, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1011, 4'b1011, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 4'b1011, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b0));
        // start another change so the async reset lands mid-WAIT
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1001, 4'b1001, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1001, 4'b1001, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1011, 4'b1001, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1011, 4'b1011, 1'b1, 1'b1));
        // sequence restarting from ch_on = 0 after the reset pulse
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1));
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1));
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b1));
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b1));
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b1));
        tbl2.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011, 4'b0001, 1'b0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // asynchronous reset in the middle of WAIT, checked before any clock edge
        arst = 1'b1;
        #1;
        chk("async_rclk_en", 0, {12'd0, rclk_en}, 16'd0);
        chk("async_cluster_grst_l", 0, {12'd0, cl_grst_l}, 16'd0);
        chk("async_so", 0, {15'd0, so}, 16'd0);
        chk("async_seq_busy", 0, {15'd0, busy}, 16'd0);
        #1;
        arst = 1'b0;

        for (int i = 0; i < tbl2.size(); i++) begin
            run_vec(tbl2[i], 100 + i);
        end

        // STAGGER = 1: channels 1 and 3 switch on consecutive cycles
        cken1 = 4'b1010;
        tick();
        chk("s1_rclk_en", 0, {12'd0, rclk1}, 16'h0000);
        chk("s1_seq_busy", 0, {15'd0, busy1}, 16'd0);
        tick();
        chk("s1_rclk_en", 1, {12'd0, rclk1}, 16'h0000);
        chk("s1_seq_busy", 1, {15'd0, busy1}, 16'd1);
        tick();
        chk("s1_rclk_en", 2, {12'd0, rclk1}, 16'h0002);
        chk("s1_seq_busy", 2, {15'd0, busy1}, 16'd1);
        tick();
        chk("s1_rclk_en", 3, {12'd0, rclk1}, 16'h000a);
        chk("s1_seq_busy", 3, {15'd0, busy1}, 16'd0);
        tick();
        chk("s1_cluster_grst_l", 4, {12'd0, grst1}, 16'h000a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
